// File: rtl/ram_queue_ctrl.sv
// FIFO sequencer for one single-port RAM, with a prefetched one-entry output register.
// Define ALMOST_FLAGS_EN to add registered almost_full/almost_empty outputs.
module ram_queue_ctrl #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 4
`ifdef ALMOST_FLAGS_EN
   ,
   parameter int AF_LEVEL = (2 ** ADDR_WIDTH) - 2,
   parameter int AE_LEVEL = 2
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  ram_write_en,
   output logic                  ram_read_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic [ADDR_WIDTH+1:0] count,
   output logic                  full,
   output logic                  empty
`ifdef ALMOST_FLAGS_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   typedef enum logic {GNT_PUSH = 1'b0, GNT_FETCH = 1'b1} grant_t;

   logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
   logic [ADDR_WIDTH:0]   ram_count, ram_count_nxt;
   logic                  fetch_pending, fetch_pending_nxt;
   logic                  out_valid, out_valid_nxt;
   logic [DATA_WIDTH-1:0] out_reg, out_reg_nxt;
   grant_t                last_grant, last_grant_nxt;

   logic ram_full, fetch_req, do_push, do_fetch, do_pop;
   logic [ADDR_WIDTH+1:0] count_int;

   always_comb begin
      ram_full   = (ram_count == DEPTH_C);
      fetch_req  = (ram_count != '0) && !fetch_pending && (!out_valid || pop_ready);
      push_ready = !rst && !ram_full && !(fetch_req && last_grant == GNT_PUSH);
      do_push    = push_valid && push_ready;
      do_fetch   = !rst && fetch_req && !do_push;
      pop_valid  = !rst && out_valid;
      do_pop     = pop_valid && pop_ready;
      pop_data   = out_reg;

      ram_write_en = do_push;
      ram_read_en  = do_fetch;
      ram_data_in  = push_data;
      ram_addr     = wr_ptr;
      if (rst)
         ram_addr = '0;
      else if (do_fetch)
         ram_addr = rd_ptr;

      count_int = (ADDR_WIDTH+2)'(ram_count)
                + (ADDR_WIDTH+2)'(fetch_pending)
                + (ADDR_WIDTH+2)'(out_valid);
      count = rst ? '0 : count_int;
      full  = !rst && ram_full;
      empty = (count == '0);
   end

   always_comb begin
      wr_ptr_nxt        = wr_ptr;
      rd_ptr_nxt        = rd_ptr;
      ram_count_nxt     = ram_count;
      last_grant_nxt    = last_grant;
      fetch_pending_nxt = do_fetch;
      out_valid_nxt     = out_valid;
      out_reg_nxt       = out_reg;

      if (do_push) begin
         wr_ptr_nxt     = wr_ptr + PTR_ONE;
         ram_count_nxt  = ram_count + CNT_ONE;
         last_grant_nxt = GNT_PUSH;
      end else if (do_fetch) begin
         rd_ptr_nxt    = rd_ptr + PTR_ONE;
         ram_count_nxt = ram_count - CNT_ONE;
         if (push_valid && !ram_full)
            last_grant_nxt = GNT_FETCH;
      end

      // a capture always wins over a pop of the previous head
      if (fetch_pending) begin
         out_reg_nxt   = ram_data_out;
         out_valid_nxt = 1'b1;
      end else if (do_pop) begin
         out_valid_nxt = 1'b0;
      end
   end

`ifdef ALMOST_FLAGS_EN
   logic [ADDR_WIDTH+1:0] count_nxt;
   assign count_nxt = (ADDR_WIDTH+2)'(ram_count_nxt)
                    + (ADDR_WIDTH+2)'(fetch_pending_nxt)
                    + (ADDR_WIDTH+2)'(out_valid_nxt);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         ram_count     <= '0;
         fetch_pending <= 1'b0;
         out_valid     <= 1'b0;
         out_reg       <= '0;
         last_grant    <= GNT_FETCH;
`ifdef ALMOST_FLAGS_EN
         almost_full   <= 1'b0;
         almost_empty  <= 1'b1;
`endif
      end else begin
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         ram_count     <= ram_count_nxt;
         fetch_pending <= fetch_pending_nxt;
         out_valid     <= out_valid_nxt;
         out_reg       <= out_reg_nxt;
         last_grant    <= last_grant_nxt;
`ifdef ALMOST_FLAGS_EN
         almost_full   <= (int'(count_nxt) >= AF_LEVEL);
         almost_empty  <= (int'(count_nxt) <= AE_LEVEL);
`endif
      end
   end

endmodule
